// File: rtl/multicycle_control.sv
// Multicycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the register-file/ALU datapath.
// Supports ADD, SUB, ADDI, BEQ and BNE; any other encoding parks the unit in HALT until reset.
module multicycle_control #(
  parameter int                 A_WIDTH  = 5,
  parameter int                 D_WIDTH  = 32,
  parameter logic [D_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [D_WIDTH-1:0] imem_addr,
  input  logic               imem_ready,
  input  logic [D_WIDTH-1:0] imem_rdata,
  output logic [A_WIDTH-1:0] rs1,
  output logic [A_WIDTH-1:0] rs2,
  output logic [A_WIDTH-1:0] rd,
  output logic               RegWrite,
  output logic               ALUsrc,
  output logic               ALUctrl,
  output logic [D_WIDTH-1:0] ImmOp,
  input  logic               EQ,
  output logic [D_WIDTH-1:0] pc,
  output logic               instr_retired,
  output logic               illegal
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

  state_t               state_reg, state_next;
  logic [D_WIDTH-1:0]   pc_reg, pc_next;
  logic [D_WIDTH-1:0]   ir_reg;
  logic [A_WIDTH-1:0]   rs1_reg, rs2_reg, rd_reg;
  logic [D_WIDTH-1:0]   imm_reg;
  logic                 alusrc_reg, aluctrl_reg;
  logic                 branch_reg, bne_reg;
  logic                 illegal_reg;

  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic [6:0]           funct7;
  logic                 dec_addi, dec_add, dec_sub, dec_beq, dec_bne, dec_legal;
  logic [D_WIDTH-1:0]   imm_i, imm_b, dec_imm;
  logic                 branch_taken;

  assign opcode = ir_reg[6:0];
  assign funct3 = ir_reg[14:12];
  assign funct7 = ir_reg[31:25];

  assign dec_addi  = (opcode == 7'b0010011) && (funct3 == 3'b000);
  assign dec_add   = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
  assign dec_sub   = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
  assign dec_beq   = (opcode == 7'b1100011) && (funct3 == 3'b000);
  assign dec_bne   = (opcode == 7'b1100011) && (funct3 == 3'b001);
  assign dec_legal = dec_addi | dec_add | dec_sub | dec_beq | dec_bne;

  assign imm_i = {{(D_WIDTH-12){ir_reg[31]}}, ir_reg[31:20]};
  assign imm_b = {{(D_WIDTH-13){ir_reg[31]}}, ir_reg[31], ir_reg[7], ir_reg[30:25],
                  ir_reg[11:8], 1'b0};

  always_comb begin
    dec_imm = '0;
    if (dec_addi) begin
      dec_imm = imm_i;
    end else if (dec_beq || dec_bne) begin
      dec_imm = imm_b;
    end
  end

  assign branch_taken = bne_reg ? ~EQ : EQ;

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    imem_req      = 1'b0;
    RegWrite      = 1'b0;
    instr_retired = 1'b0;
    case (state_reg)
      S_FETCH: begin
        // Gated by rst_n so the request is low while reset is held, not just after it.
        imem_req = rst_n;
        if (imem_ready) begin
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        state_next = dec_legal ? S_EXECUTE : S_HALT;
      end
      S_EXECUTE: begin
        if (branch_reg) begin
          instr_retired = 1'b1;
          pc_next       = branch_taken ? (pc_reg + imm_reg) : (pc_reg + D_WIDTH'(4));
          state_next    = S_FETCH;
        end else begin
          state_next = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        RegWrite      = (rd_reg != '0);
        instr_retired = 1'b1;
        pc_next       = pc_reg + D_WIDTH'(4);
        state_next    = S_FETCH;
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_FETCH;
      pc_reg      <= RESET_PC;
      ir_reg      <= '0;
      rs1_reg     <= '0;
      rs2_reg     <= '0;
      rd_reg      <= '0;
      imm_reg     <= '0;
      alusrc_reg  <= 1'b0;
      aluctrl_reg <= 1'b0;
      branch_reg  <= 1'b0;
      bne_reg     <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      if (state_reg == S_FETCH && imem_ready) begin
        ir_reg <= imem_rdata;
      end
      // An illegal word leaves the previous controls in place; only the sticky flag changes.
      if (state_reg == S_DECODE) begin
        if (dec_legal) begin
          rs1_reg     <= ir_reg[19:15];
          rs2_reg     <= ir_reg[24:20];
          rd_reg      <= ir_reg[11:7];
          imm_reg     <= dec_imm;
          alusrc_reg  <= dec_addi;
          aluctrl_reg <= dec_sub | dec_beq | dec_bne;
          branch_reg  <= dec_beq | dec_bne;
          bne_reg     <= dec_bne;
        end else begin
          illegal_reg <= 1'b1;
        end
      end
    end
  end

  assign imem_addr = pc_reg;
  assign pc        = pc_reg;
  assign rs1       = rs1_reg;
  assign rs2       = rs2_reg;
  assign rd        = rd_reg;
  assign ImmOp     = imm_reg;
  assign ALUsrc    = alusrc_reg;
  assign ALUctrl   = aluctrl_reg;
  assign illegal   = illegal_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: an instruction-level model sets per-cycle expectations
// that a negedge compare process checks, plus literal pins on key PC/immediate values.
module tb_multicycle_control;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          imem_req;
  logic [DW-1:0] imem_addr;
  logic          imem_ready;
  logic [DW-1:0] imem_rdata;
  logic [AW-1:0] rs1, rs2, rd;
  logic          RegWrite, ALUsrc, ALUctrl;
  logic [DW-1:0] ImmOp;
  logic          EQ;
  logic [DW-1:0] pc;
  logic          instr_retired;
  logic          illegal;

  int n_vec = 0;
  int n_err = 0;

  // Expected values for the current cycle, maintained by the instruction-level model.
  logic          exp_en = 1'b0;
  logic          exp_req, exp_rw, exp_ret, exp_ill, exp_fv;
  logic [DW-1:0] exp_pc, exp_imm;
  logic [AW-1:0] exp_rs1, exp_rs2, exp_rd;
  logic          exp_src, exp_ctrl;
  logic [DW-1:0] model_pc;

  always #5 clk = ~clk;

  multicycle_control #(.A_WIDTH(AW), .D_WIDTH(DW), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .rs1(rs1), .rs2(rs2), .rd(rd), .RegWrite(RegWrite), .ALUsrc(ALUsrc), .ALUctrl(ALUctrl),
    .ImmOp(ImmOp), .EQ(EQ), .pc(pc), .instr_retired(instr_retired), .illegal(illegal)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_en) begin
      check("imem_req", 32'(imem_req), 32'(exp_req));
      check("imem_addr", imem_addr, exp_pc);
      check("pc", pc, exp_pc);
      check("RegWrite", 32'(RegWrite), 32'(exp_rw));
      check("instr_retired", 32'(instr_retired), 32'(exp_ret));
      check("illegal", 32'(illegal), 32'(exp_ill));
      if (exp_fv) begin
        check("rs1", 32'(rs1), 32'(exp_rs1));
        check("rs2", 32'(rs2), 32'(exp_rs2));
        check("rd", 32'(rd), 32'(exp_rd));
        check("ImmOp", ImmOp, exp_imm);
        check("ALUsrc", 32'(ALUsrc), 32'(exp_src));
        check("ALUctrl", 32'(ALUctrl), 32'(exp_ctrl));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // 0 illegal, 1 ADDI, 2 ADD, 3 SUB, 4 BEQ, 5 BNE
  function automatic int classify(input logic [31:0] w);
    if (w[6:0] == 7'h13 && w[14:12] == 3'd0) return 1;
    if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[31:25] == 7'h00) return 2;
    if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[31:25] == 7'h20) return 3;
    if (w[6:0] == 7'h63 && w[14:12] == 3'd0) return 4;
    if (w[6:0] == 7'h63 && w[14:12] == 3'd1) return 5;
    return 0;
  endfunction

  function automatic logic [31:0] expected_imm(input logic [31:0] w, input int kind);
    int v;
    v = 0;
    if (kind == 1) begin
      v = int'(w[31:20]);
      if (v >= 2048) v = v - 4096;
    end else if (kind >= 4) begin
      v = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
      if (v >= 4096) v = v - 8192;
    end
    return 32'(v);
  endfunction

  task automatic set_reset_expect();
    exp_req = 1'b0; exp_rw = 1'b0; exp_ret = 1'b0; exp_ill = 1'b0;
    exp_pc = 32'h0; exp_fv = 1'b1;
    exp_rs1 = '0; exp_rs2 = '0; exp_rd = '0; exp_imm = '0; exp_src = 1'b0; exp_ctrl = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = $urandom;
    set_reset_expect();
    exp_en = 1'b1;
    #1;
    check("reset_pc", pc, 32'h0);
    check("reset_req", 32'(imem_req), 32'h0);
    check("reset_regwrite", 32'(RegWrite), 32'h0);
    for (int i = 0; i < cycles; i++) step();
    rst_n = 1'b1;
    model_pc = 32'h0;
    exp_req = 1'b1;
    exp_pc = model_pc;
    $display("reset released after %0d cycles", cycles);
  endtask

  // Drives one instruction through the unit. abort_wb asserts rst_n in the middle of WRITEBACK.
  task automatic run_instr(input logic [31:0] w, input int stall, input logic eq, input bit abort_wb);
    int            kind;
    logic [31:0]   imm;
    logic [31:0]   start_pc;
    logic          taken;
    kind = classify(w);
    imm = expected_imm(w, kind);
    start_pc = model_pc;
    exp_pc = model_pc; exp_req = 1'b1; exp_rw = 1'b0; exp_ret = 1'b0;
    for (int i = 0; i < stall; i++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      step();
    end
    imem_ready = 1'b1;
    imem_rdata = w;
    step();
    // decode cycle; imem_ready must be ignored from here on
    exp_req = 1'b0;
    imem_rdata = $urandom;
    step();
    if (kind == 0) begin
      exp_ill = 1'b1;
      exp_fv = 1'b0;
      for (int i = 0; i < 4; i++) step();
      $display("instr %08h at pc %08h -> illegal, halted", w, start_pc);
      return;
    end
    exp_fv = 1'b1;
    exp_rs1 = w[19:15]; exp_rs2 = w[24:20]; exp_rd = w[11:7];
    exp_imm = imm;
    exp_src = (kind == 1);
    exp_ctrl = (kind == 3) || (kind >= 4);
    EQ = eq;
    exp_ret = (kind >= 4);
    step();
    EQ = 1'b0;
    if (kind >= 4) begin
      taken = (kind == 4) ? eq : !eq;
      model_pc = taken ? (model_pc + imm) : (model_pc + 32'd4);
    end else begin
      exp_rw = (w[11:7] != 5'd0);
      exp_ret = 1'b1;
      if (abort_wb) begin
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        set_reset_expect();
        #1;
        check("abort_regwrite", 32'(RegWrite), 32'h0);
        check("abort_pc", pc, 32'h0);
        check("abort_illegal", 32'(illegal), 32'h0);
        check("abort_retired", 32'(instr_retired), 32'h0);
        @(posedge clk);
        #1;
        $display("instr %08h at pc %08h -> reset during writeback", w, start_pc);
        return;
      end
      step();
      model_pc = model_pc + 32'd4;
    end
    exp_rw = 1'b0; exp_ret = 1'b0; exp_req = 1'b1;
    exp_pc = model_pc;
    imem_ready = 1'b0;
    $display("instr %08h at pc %08h -> next pc %08h", w, start_pc, model_pc);
  endtask

  initial begin
    rst_n = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'h0;
    EQ = 1'b0;
    model_pc = 32'h0;
    set_reset_expect();
    #1;
    do_reset(3);

    run_instr(32'h0050_0513, 0, 1'b0, 1'b0);
    check("pin_pc_after_addi", pc, 32'h0000_0004);
    run_instr(32'hFFF0_0093, 0, 1'b0, 1'b0);
    check("pin_imm_minus1", ImmOp, 32'hFFFF_FFFF);
    run_instr(32'hFE05_1EE3, 0, 1'b0, 1'b0);
    check("pin_bne_taken_pc", pc, 32'h0000_0004);
    check("pin_bne_aluctrl", 32'(ALUctrl), 32'h1);
    run_instr(32'h0010_0013, 0, 1'b0, 1'b0);
    check("pin_pc_after_x0", pc, 32'h0000_0008);
    run_instr(32'hFE05_1EE3, 0, 1'b1, 1'b0);
    check("pin_bne_not_taken_pc", pc, 32'h0000_000C);
    run_instr(32'h0020_81B3, 3, 1'b0, 1'b0);
    run_instr(32'h4073_02B3, 1, 1'b0, 1'b0);
    check("pin_sub_aluctrl", 32'(ALUctrl), 32'h1);
    run_instr(32'h0010_8463, 0, 1'b1, 1'b0);
    check("pin_beq_taken_pc", pc, 32'h0000_001C);
    run_instr(32'h0010_8463, 2, 1'b0, 1'b0);
    check("pin_beq_not_taken_pc", pc, 32'h0000_0020);
    run_instr(32'h0000_0000, 0, 1'b0, 1'b0);
    check("pin_halt_pc", pc, 32'h0000_0020);
    check("pin_halt_illegal", 32'(illegal), 32'h1);
    check("pin_halt_req", 32'(imem_req), 32'h0);

    do_reset(2);
    run_instr(32'hFE00_0EE3, 0, 1'b1, 1'b0);
    check("pin_branch_to_top", pc, 32'hFFFF_FFFC);
    run_instr(32'h0050_0513, 0, 1'b0, 1'b0);
    check("pin_pc_wrap", pc, 32'h0000_0000);
    run_instr(32'h0020_81B3, 0, 1'b0, 1'b1);

    do_reset(1);
    run_instr(32'h0050_0513, 0, 1'b0, 1'b0);
    check("pin_pc_after_reset", pc, 32'h0000_0004);
    step();
    exp_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
